// File: rtl/nav_key_events.sv
// Navigation key debouncer with press/release event queue.
// Debounced edges become 8-bit codes held in a first-word-fall-through FIFO.
module nav_key_events #(
    parameter int NUM_KEYS    = 5,
    parameter int DEB_SAMPLES = 4,
    parameter int FIFO_AW     = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_en,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key_state,
    input  logic                evt_rd,
    output logic [7:0]          evt_data,
    output logic                evt_empty,
    output logic [FIFO_AW:0]    evt_count,
    output logic                evt_overflow,
    input  logic                ovf_clr,
    output logic                irq
);

    localparam int               DEPTH_I = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH   = (FIFO_AW + 1)'(DEPTH_I);
    localparam logic [3:0]       DEB_TH  = 4'(DEB_SAMPLES);

    logic [NUM_KEYS-1:0]       key_state_q, key_state_d;
    logic [NUM_KEYS-1:0][3:0]  cnt_q, cnt_d;
    logic [NUM_KEYS-1:0]       pend_vld_q, pend_vld_d;
    logic [NUM_KEYS-1:0]       pend_dir_q, pend_dir_d;
    logic [NUM_KEYS-1:0]       new_evt;
    logic                      pend_ovf;

    logic                      sel_vld;
    logic [2:0]                sel_idx;
    logic [7:0]                push_data;
    logic                      full, push, pop, drop;

    logic [7:0]                mem_q [DEPTH_I];
    logic [FIFO_AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]          count_q, count_d;
    logic                      ovf_q, ovf_d;

    always_comb begin
        key_state_d = key_state_q;
        cnt_d       = cnt_q;
        new_evt     = '0;
        if (sample_en) begin
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                if (key_raw[i] == key_state_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] + 4'd1 == DEB_TH) begin
                    key_state_d[i] = key_raw[i];
                    cnt_d[i]       = '0;
                    new_evt[i]     = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 4'd1;
                end
            end
        end
    end

    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (pend_vld_q[i] && !sel_vld) begin
                sel_vld = 1'b1;
                sel_idx = 3'(i);
            end
        end
    end

    // An entry being drained by the arbiter this cycle is not lost when re-armed.
    always_comb begin
        pend_vld_d = pend_vld_q;
        pend_dir_d = pend_dir_q;
        pend_ovf   = 1'b0;
        if (sel_vld) pend_vld_d[sel_idx] = 1'b0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (new_evt[i]) begin
                if (pend_vld_q[i] && !(sel_vld && sel_idx == 3'(i))) pend_ovf = 1'b1;
                pend_vld_d[i] = 1'b1;
                pend_dir_d[i] = key_raw[i];
            end
        end
    end

    assign push_data = {pend_dir_q[sel_idx], 4'b0000, sel_idx};
    assign full      = (count_q == DEPTH);
    assign pop       = evt_rd && (count_q != '0);
    assign push      = sel_vld && (!full || pop);
    assign drop      = sel_vld && !push;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr)         ovf_d = 1'b0;
        if (drop || pend_ovf) ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_state_q <= '0;
            cnt_q       <= '0;
            pend_vld_q  <= '0;
            pend_dir_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            key_state_q <= key_state_d;
            cnt_q       <= cnt_d;
            pend_vld_q  <= pend_vld_d;
            pend_dir_q  <= pend_dir_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) mem_q[wr_ptr_q] <= push_data;
    end

    assign key_state    = key_state_q;
    assign evt_count    = count_q;
    assign evt_empty    = (count_q == '0);
    assign irq          = (count_q != '0);
    assign evt_overflow = ovf_q;
    assign evt_data     = (count_q != '0) ? mem_q[rd_ptr_q] : 8'h00;

endmodule

// File: tb/tb_nav_key_events.sv
// Directed bench for nav_key_events: debounce, event order, FIFO bounds, overflow, reset.
module tb_nav_key_events;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sample_en = 1'b0;
    logic [4:0] key_raw = '0;
    logic [4:0] key_state;
    logic       evt_rd = 1'b0;
    logic [7:0] evt_data;
    logic       evt_empty;
    logic [3:0] evt_count;
    logic       evt_overflow;
    logic       ovf_clr = 1'b0;
    logic       irq;

    int total = 0;
    int bad   = 0;

    nav_key_events #(.NUM_KEYS(5), .DEB_SAMPLES(4), .FIFO_AW(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_en    (sample_en),
        .key_raw      (key_raw),
        .key_state    (key_state),
        .evt_rd       (evt_rd),
        .evt_data     (evt_data),
        .evt_empty    (evt_empty),
        .evt_count    (evt_count),
        .evt_overflow (evt_overflow),
        .ovf_clr      (ovf_clr),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [4:0] raw);
        key_raw   = raw;
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
    endtask

    task automatic sample4(input logic [4:0] raw);
        for (int i = 0; i < 4; i++) sample(raw);
    endtask

    task automatic pop();
        evt_rd = 1'b1;
        tick();
        evt_rd = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".key_state"}, 32'(key_state), 32'h0);
        check({tag, ".empty"},     32'(evt_empty), 32'h1);
        check({tag, ".count"},     32'(evt_count), 32'h0);
        check({tag, ".data"},      32'(evt_data), 32'h00);
        check({tag, ".ovf"},       32'(evt_overflow), 32'h0);
        check({tag, ".irq"},       32'(irq), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] drain_exp [8];
        drain_exp = '{8'h01, 8'h04, 8'h82, 8'h83, 8'h02, 8'h03, 8'h80, 8'h80};

        tick(); tick();
        rst = 1'b0;
        check_reset_vals("rst0");

        // basic press / release
        sample4(5'b00100);
        check("press.key_state", 32'(key_state), 32'h04);
        check("press.count_n1", 32'(evt_count), 32'h0);
        tick();
        check("press.data", 32'(evt_data), 32'h82);
        check("press.count", 32'(evt_count), 32'h1);
        check("press.irq", 32'(irq), 32'h1);
        pop();
        check("rd.empty", 32'(evt_empty), 32'h1);
        check("rd.data", 32'(evt_data), 32'h00);
        check("rd.irq", 32'(irq), 32'h0);
        pop();
        check("rd_empty.count", 32'(evt_count), 32'h0);
        sample4(5'b00000);
        tick();
        check("release.data", 32'(evt_data), 32'h02);
        check("release.count", 32'(evt_count), 32'h1);
        pop();

        // bounce rejection on key 0
        for (int i = 0; i < 3; i++) sample(5'b00001);
        sample(5'b00000);
        for (int i = 0; i < 3; i++) sample(5'b00001);
        tick(); tick();
        check("bounce.count", 32'(evt_count), 32'h0);
        check("bounce.key_state", 32'(key_state), 32'h0);
        sample(5'b00001);
        tick();
        check("bounce4.data", 32'(evt_data), 32'h80);
        pop();
        sample4(5'b00000);
        tick();
        check("k0rel.data", 32'(evt_data), 32'h00);
        pop();

        // keys 4, 1, 0 together
        sample4(5'b10011);
        check("simul.count0", 32'(evt_count), 32'h0);
        tick();
        check("simul.count1", 32'(evt_count), 32'h1);
        tick();
        check("simul.count2", 32'(evt_count), 32'h2);
        tick();
        check("simul.count3", 32'(evt_count), 32'h3);
        check("simul.ev0", 32'(evt_data), 32'h80);
        pop();
        check("simul.ev1", 32'(evt_data), 32'h81);
        pop();
        check("simul.ev2", 32'(evt_data), 32'h84);
        pop();
        check("simul.empty", 32'(evt_empty), 32'h1);

        // nine events into an eight-deep FIFO
        sample4(5'b00000);
        sample4(5'b01100);
        sample4(5'b00000);
        sample4(5'b00001);
        sample4(5'b00000);
        tick(); tick();
        check("ovf.count", 32'(evt_count), 32'h8);
        check("ovf.flag", 32'(evt_overflow), 32'h1);
        check("ovf.head", 32'(evt_data), 32'h00);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf.clr", 32'(evt_overflow), 32'h0);
        sample4(5'b00001);
        pop();
        check("fullpp.count", 32'(evt_count), 32'h8);
        check("fullpp.ovf", 32'(evt_overflow), 32'h0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain%0d", i), 32'(evt_data), 32'(drain_exp[i]));
            pop();
        end
        check("drain.empty", 32'(evt_empty), 32'h1);

        // push and pop together at count 1
        sample4(5'b00000);
        tick();
        check("pp1.pre", 32'(evt_data), 32'h00);
        sample4(5'b00010);
        pop();
        check("pp1.count", 32'(evt_count), 32'h1);
        check("pp1.data", 32'(evt_data), 32'h81);
        pop();

        // reset with queued events and key 3 held
        sample4(5'b01000);
        sample4(5'b01100);
        sample4(5'b01000);
        sample4(5'b01100);
        tick(); tick();
        check("prerst.count", 32'(evt_count), 32'h5);
        check("prerst.key3", 32'(key_state[3]), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_vals("rst1");
        sample4(5'b01000);
        check("postrst.key_state", 32'(key_state), 32'h08);
        tick();
        check("postrst.data", 32'(evt_data), 32'h83);
        check("postrst.count", 32'(evt_count), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
